// File: rtl/img_phase_sequencer_if.sv
// Image SRAM request bundle: address, write data and the two enables.
// Engines drive it as master; the sequencer receives engine requests as
// slave and drives the SRAM macro as master.
interface img_phase_sequencer_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic [ADDR_W-1:0] row;
  logic [ADDR_W-1:0] col;
  logic [DATA_W-1:0] din;
  logic              we;
  logic              se;

  modport master (output row, col, din, we, se);
  modport slave  (input  row, col, din, we, se);
endinterface

// File: rtl/img_phase_sequencer.sv
// img_phase_sequencer: runs one image job as rx -> conv -> tx.
// Each phase pulses its engine enable, waits for the engine busy to rise
// (or times out), waits for it to fall, then hands the single image SRAM
// port to the next engine. The SRAM mux follows the registered grant.
module img_phase_sequencer #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned START_TO = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         cfg_bypass,
  input  logic                         rx_busy,
  input  logic                         conv_busy,
  input  logic                         tx_busy,
  output logic                         rx_en,
  output logic                         conv_en,
  output logic                         tx_en,
  img_phase_sequencer_if.slave         m0,
  img_phase_sequencer_if.slave         m1,
  img_phase_sequencer_if.slave         m2,
  img_phase_sequencer_if.master        sram,
  output logic [2:0]                   grant,
  output logic                         busy,
  output logic                         done,
  output logic [2:0]                   nobusy
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StLaunch   = 3'd1,
    StWaitRise = 3'd2,
    StWaitFall = 3'd3,
    StFinish   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    PhRx   = 2'd0,
    PhConv = 2'd1,
    PhTx   = 2'd2
  } phase_e;

  localparam logic [3:0] TimeoutCnt = 4'(START_TO);

  // FSM state and registered outputs
  state_e      r_state;
  phase_e      r_phase;
  logic        r_bypass;
  logic [3:0]  r_cnt;
  logic [2:0]  r_grant;
  logic [2:0]  r_nobusy;
  logic        r_busy;
  logic        r_done;
  logic        r_rx_en;
  logic        r_conv_en;
  logic        r_tx_en;

  // Decode helpers
  logic        w_sel_busy;
  logic [2:0]  w_cur_onehot;
  logic [2:0]  w_next_onehot;
  phase_e      w_next_phase;
  logic [3:0]  w_cnt_inc;
  logic        w_timeout;
  logic        w_phase_done;

  // SRAM mux result
  logic [ADDR_W-1:0] w_row;
  logic [ADDR_W-1:0] w_col;
  logic [DATA_W-1:0] w_din;
  logic              w_we;
  logic              w_se;

  function automatic logic [2:0] phase_onehot(input phase_e ph);
    logic [2:0] oh;
    case (ph)
      PhRx:    oh = 3'b001;
      PhConv:  oh = 3'b010;
      PhTx:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  // Select the busy flag of the engine that owns the current phase.
  always_comb begin
    w_sel_busy = 1'b0;
    case (r_phase)
      PhRx:    w_sel_busy = rx_busy;
      PhConv:  w_sel_busy = conv_busy;
      PhTx:    w_sel_busy = tx_busy;
      default: w_sel_busy = 1'b0;
    endcase
  end

  // Phase sequencing: bypass skips conv; tx is always the last phase.
  always_comb begin
    w_next_phase = PhTx;
    case (r_phase)
      PhRx:    w_next_phase = r_bypass ? PhTx : PhConv;
      default: w_next_phase = PhTx;
    endcase
    w_cur_onehot  = phase_onehot(r_phase);
    w_next_onehot = phase_onehot(w_next_phase);
  end

  // Rise-timeout detection and phase completion (busy fell, or never rose).
  always_comb begin
    w_cnt_inc    = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;
    w_timeout    = (r_state == StWaitRise) && !w_sel_busy && (w_cnt_inc == TimeoutCnt);
    w_phase_done = w_timeout || ((r_state == StWaitFall) && !w_sel_busy);
  end

  // Main FSM with registered enables, grant, busy, done and nobusy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= StIdle;
      r_phase   <= PhRx;
      r_bypass  <= 1'b0;
      r_cnt     <= 4'd0;
      r_grant   <= 3'b000;
      r_nobusy  <= 3'b000;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rx_en   <= 1'b0;
      r_conv_en <= 1'b0;
      r_tx_en   <= 1'b0;
    end else begin
      // Enables and done are single-cycle pulses unless re-armed below.
      r_rx_en   <= 1'b0;
      r_conv_en <= 1'b0;
      r_tx_en   <= 1'b0;
      r_done    <= 1'b0;

      if (abort && (r_state != StIdle)) begin
        r_state <= StIdle;
        r_grant <= 3'b000;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          StIdle: begin
            // abort in the same cycle suppresses the start
            if (start && !abort) begin
              r_state  <= StLaunch;
              r_phase  <= PhRx;
              r_bypass <= cfg_bypass;
              r_nobusy <= 3'b000;
              r_grant  <= 3'b001;
              r_busy   <= 1'b1;
              r_rx_en  <= 1'b1;
            end
          end

          StLaunch: begin
            r_cnt   <= 4'd0;
            r_state <= StWaitRise;
          end

          StWaitRise, StWaitFall: begin
            if (r_state == StWaitRise) begin
              if (w_sel_busy) begin
                r_state <= StWaitFall;
              end else begin
                r_cnt <= w_cnt_inc;
              end
            end

            if (w_timeout) begin
              r_nobusy <= r_nobusy | w_cur_onehot;
            end

            if (w_phase_done) begin
              if (r_phase == PhTx) begin
                r_state <= StFinish;
                r_grant <= 3'b000;
                r_done  <= 1'b1;
              end else begin
                // Grant moves with the launch so the next engine owns SRAM
                // from its enable cycle onward.
                r_state   <= StLaunch;
                r_phase   <= w_next_phase;
                r_grant   <= w_next_onehot;
                r_rx_en   <= w_next_onehot[0];
                r_conv_en <= w_next_onehot[1];
                r_tx_en   <= w_next_onehot[2];
              end
            end
          end

          StFinish: begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end

          default: begin
            r_state <= StIdle;
            r_grant <= 3'b000;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // SRAM mux from the registered grant; no grant parks the port at zero.
  always_comb begin
    w_row = '0;
    w_col = '0;
    w_din = '0;
    w_we  = 1'b0;
    w_se  = 1'b0;
    case (r_grant)
      3'b001: begin
        w_row = m0.row;
        w_col = m0.col;
        w_din = m0.din;
        w_we  = m0.we;
        w_se  = m0.se;
      end
      3'b010: begin
        w_row = m1.row;
        w_col = m1.col;
        w_din = m1.din;
        w_we  = m1.we;
        w_se  = m1.se;
      end
      3'b100: begin
        w_row = m2.row;
        w_col = m2.col;
        w_din = m2.din;
        w_we  = m2.we;
        w_se  = m2.se;
      end
      default: begin
        w_row = '0;
      end
    endcase
  end

  assign sram.row = w_row;
  assign sram.col = w_col;
  assign sram.din = w_din;
  assign sram.we  = w_we;
  assign sram.se  = w_se;

  assign rx_en   = r_rx_en;
  assign conv_en = r_conv_en;
  assign tx_en   = r_tx_en;
  assign grant   = r_grant;
  assign busy    = r_busy;
  assign done    = r_done;
  assign nobusy  = r_nobusy;

endmodule

// File: tb/tb_img_phase_sequencer.sv
// Bench for img_phase_sequencer: engine models answer the enable pulses,
// a scoreboard holds the expected pulse sequence with cycle stamps.
module tb_img_phase_sequencer;

  localparam int unsigned AW  = 8;
  localparam int unsigned DW  = 8;
  localparam int unsigned STO = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       cfg_bypass = 1'b0;
  logic [2:0] eng_busy = 3'b000;
  logic       rx_en, conv_en, tx_en;
  logic [2:0] grant, nobusy;
  logic       busy, done;

  img_phase_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) m0_if ();
  img_phase_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) m1_if ();
  img_phase_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) m2_if ();
  img_phase_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) sram_if ();

  img_phase_sequencer #(.ADDR_W(AW), .DATA_W(DW), .START_TO(STO)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .abort      (abort),
    .cfg_bypass (cfg_bypass),
    .rx_busy    (eng_busy[0]),
    .conv_busy  (eng_busy[1]),
    .tx_busy    (eng_busy[2]),
    .rx_en      (rx_en),
    .conv_en    (conv_en),
    .tx_en      (tx_en),
    .m0         (m0_if),
    .m1         (m1_if),
    .m2         (m2_if),
    .sram       (sram_if),
    .grant      (grant),
    .busy       (busy),
    .done       (done),
    .nobusy     (nobusy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Master request fields, distinct per engine.
  logic [7:0] mrow [3] = '{8'h11, 8'h21, 8'h31};
  logic [7:0] mcol [3] = '{8'h12, 8'h22, 8'h32};
  logic [7:0] mdin [3] = '{8'h13, 8'h23, 8'h33};
  logic       mse  [3] = '{1'b1, 1'b0, 1'b1};

  // Engine models: busy rises 1 cycle after en, held for 'hold' cycles.
  logic [2:0] eng_dead = 3'b000;
  int         hold = 20;
  logic       eng_kill = 1'b0;
  int         eng_cnt [3];
  logic       eng_act [3];

  always @(negedge clk) begin : engines
    logic [2:0] en_vec;
    en_vec = {tx_en, conv_en, rx_en};
    if (!rstn || eng_kill) begin
      eng_busy = 3'b000;
      for (int i = 0; i < 3; i++) begin
        eng_act[i] = 1'b0;
        eng_cnt[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (eng_act[i]) begin
          eng_cnt[i]++;
          if (eng_cnt[i] == 1 && !eng_dead[i]) eng_busy[i] = 1'b1;
          if (eng_cnt[i] == 1 + hold) begin
            eng_busy[i] = 1'b0;
            eng_act[i]  = 1'b0;
          end
        end
        if (en_vec[i]) begin
          eng_act[i] = 1'b1;
          eng_cnt[i] = 0;
        end
      end
    end
  end

  typedef struct {
    logic [3:0] kind;   // {done, tx_en, conv_en, rx_en}
    int         cyc;
    logic [2:0] grant;
    logic [2:0] nobusy;
  } ev_t;

  ev_t sb [$];
  int  conv_grant_cnt = 0;

  // Monitor: every enable/done pulse is popped against the scoreboard.
  always @(negedge clk) begin : monitor
    logic [3:0] k;
    ev_t        e;
    int         idx;
    k = {done, tx_en, conv_en, rx_en};
    if (grant == 3'b010) conv_grant_cnt++;
    if (k != 4'b0000) begin
      if (sb.size() == 0) begin
        check_val("unexpected_pulse", {28'd0, k}, 32'd0);
      end else begin
        e = sb.pop_front();
        check_val("pulse_kind", {28'd0, k}, {28'd0, e.kind});
        check_val("pulse_cycle", cyc, e.cyc);
        check_val("pulse_grant", {29'd0, grant}, {29'd0, e.grant});
        check_val("pulse_nobusy", {29'd0, nobusy}, {29'd0, e.nobusy});
        check_val("pulse_busy", {31'd0, busy}, 32'd1);
        if (e.grant == 3'b000) begin
          check_val("idle_sram_we", {31'd0, sram_if.we}, 32'd0);
          check_val("idle_sram_se", {31'd0, sram_if.se}, 32'd0);
          check_val("idle_sram_row", {24'd0, sram_if.row}, 32'd0);
        end else begin
          idx = e.grant[1] ? 1 : (e.grant[2] ? 2 : 0);
          check_val("mux_row", {24'd0, sram_if.row}, {24'd0, mrow[idx]});
          check_val("mux_col", {24'd0, sram_if.col}, {24'd0, mcol[idx]});
          check_val("mux_din", {24'd0, sram_if.din}, {24'd0, mdin[idx]});
          check_val("mux_se", {31'd0, sram_if.se}, {31'd0, mse[idx]});
        end
      end
    end
  end

  // Expected pulse sequence for a job whose start is sampled after cycle c.
  task automatic expect_job(input int c, input logic byp, input logic [2:0] dead, input int h,
                            output int e_rx, output int e_conv, output int e_tx);
    int         e;
    int         ph;
    logic [2:0] nb;
    ev_t        ev;
    e = c + 1;
    ph = 0;
    nb = 3'b000;
    e_rx = -1;
    e_conv = -1;
    e_tx = -1;
    while (ph < 3) begin
      if (ph == 0) e_rx = e;
      if (ph == 1) e_conv = e;
      if (ph == 2) e_tx = e;
      ev.kind   = 4'(1 << ph);
      ev.cyc    = e;
      ev.grant  = 3'(1 << ph);
      ev.nobusy = nb;
      sb.push_back(ev);
      if (dead[ph]) begin
        nb[ph] = 1'b1;
        e = e + int'(STO) + 1;
      end else begin
        e = e + h + 2;
      end
      if (ph == 0 && byp) ph = 2;
      else ph = ph + 1;
    end
    ev.kind   = 4'b1000;
    ev.cyc    = e;
    ev.grant  = 3'b000;
    ev.nobusy = nb;
    sb.push_back(ev);
  endtask

  task automatic start_job(input logic byp, input logic [2:0] dead, input int h,
                           output int e_rx, output int e_conv, output int e_tx);
    @(negedge clk);
    eng_dead   = dead;
    hold       = h;
    cfg_bypass = byp;
    start      = 1'b1;
    expect_job(cyc, byp, dead, h, e_rx, e_conv, e_tx);
    @(negedge clk);
    start      = 1'b0;
    cfg_bypass = 1'b0;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic run_to_idle(input string tag, input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_pending"}, sb.size(), 32'd0);
    check_val({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_grant"}, {29'd0, grant}, 32'd0);
    check_val({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_val({tag, "_done"}, {31'd0, done}, 32'd0);
    check_val({tag, "_nobusy"}, {29'd0, nobusy}, 32'd0);
    check_val({tag, "_en"}, {29'd0, rx_en, conv_en, tx_en}, 32'd0);
    check_val({tag, "_sram_we"}, {31'd0, sram_if.we}, 32'd0);
    check_val({tag, "_sram_se"}, {31'd0, sram_if.se}, 32'd0);
    check_val({tag, "_sram_row"}, {24'd0, sram_if.row}, 32'd0);
  endtask

  int er, ec, et, n0;

  initial begin
    m0_if.row = mrow[0]; m0_if.col = mcol[0]; m0_if.din = mdin[0];
    m0_if.we = 1'b1; m0_if.se = mse[0];
    m1_if.row = mrow[1]; m1_if.col = mcol[1]; m1_if.din = mdin[1];
    m1_if.we = 1'b1; m1_if.se = mse[1];
    m2_if.row = mrow[2]; m2_if.col = mcol[2]; m2_if.din = mdin[2];
    m2_if.we = 1'b1; m2_if.se = mse[2];

    // Reset state
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rstn = 1'b1;
    @(negedge clk);

    // Full job, no bypass; explicit mux isolation while rx holds the port
    start_job(1'b0, 3'b000, 20, er, ec, et);
    wait_until(er + 5);
    check_val("iso_grant", {29'd0, grant}, 32'd1);
    check_val("iso_row", {24'd0, sram_if.row}, {24'd0, mrow[0]});
    check_val("iso_col", {24'd0, sram_if.col}, {24'd0, mcol[0]});
    check_val("iso_din", {24'd0, sram_if.din}, {24'd0, mdin[0]});
    check_val("iso_we", {31'd0, sram_if.we}, 32'd1);
    check_val("iso_se", {31'd0, sram_if.se}, {31'd0, mse[0]});
    run_to_idle("job_full", 200);
    check_val("full_nobusy", {29'd0, nobusy}, 32'd0);
    check_all_zero("post_full");

    // Bypass job; a start mid-job must be ignored
    n0 = conv_grant_cnt;
    start_job(1'b1, 3'b000, 20, er, ec, et);
    wait_until(er + 8);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_to_idle("job_bypass", 200);
    check_val("bypass_conv_grant", conv_grant_cnt - n0, 32'd0);

    // rx never raises busy: timeout, sticky nobusy, cleared by next start
    start_job(1'b0, 3'b001, 20, er, ec, et);
    run_to_idle("job_timeout", 200);
    check_val("timeout_nobusy", {29'd0, nobusy}, 32'd1);
    start_job(1'b0, 3'b000, 6, er, ec, et);
    run_to_idle("job_after_timeout", 200);
    check_val("cleared_nobusy", {29'd0, nobusy}, 32'd0);

    // Abort while conv is busy
    start_job(1'b0, 3'b000, 20, er, ec, et);
    wait_until(ec + 5);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_val("abort_busy", {31'd0, busy}, 32'd0);
    check_val("abort_grant", {29'd0, grant}, 32'd0);
    sb.delete();
    eng_kill = 1'b1;
    @(negedge clk);
    eng_kill = 1'b0;
    repeat (40) @(negedge clk);
    check_val("abort_idle_busy", {31'd0, busy}, 32'd0);

    // start and abort together in idle: no job
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check_val("start_abort_busy", {31'd0, busy}, 32'd0);
    repeat (4) @(negedge clk);

    // Clean job after abort
    start_job(1'b0, 3'b000, 5, er, ec, et);
    run_to_idle("job_after_abort", 200);

    // Asynchronous reset during tx wait-fall
    start_job(1'b0, 3'b000, 20, er, ec, et);
    wait_until(et + 5);
    #2 rstn = 1'b0;
    #1 check_all_zero("async_rst");
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    start_job(1'b0, 3'b000, 4, er, ec, et);
    run_to_idle("job_after_reset", 200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/img_phase_sequencer.md
Name: img_phase_sequencer

Overview:
- Top-level scheduler for one image job: load (rx), convolve (conv), send (tx).
- Pulses each engine's enable, waits for that engine to finish, then moves to the next phase.
- Owns the single image SRAM port. Multiplexes the three engines' SRAM request buses onto it, with exactly one engine granted at a time.
- Sits between the rx, conv and tx controllers and the image SRAM macro.

Parameters:
- ADDR_W, 8, row and column index width
- DATA_W, 8, pixel width
- START_TO, 4, cycles to wait for an engine's busy to rise after its enable pulse (range 1..15)

Ports:
- clk  in  1  system clock (same clock as the image SRAM)
- rstn  in  1  asynchronous active-low reset
- start  in  1  begin job; sampled only in IDLE
- abort  in  1  cancel the job in flight
- cfg_bypass  in  1  skip the conv phase; sampled with start
- rx_busy, conv_busy, tx_busy  in  1 each  engine busy flags
- rx_en, conv_en, tx_en  out  1 each  single-cycle engine start pulses
- m{0,1,2}_row, m{0,1,2}_col  in  ADDR_W each  SRAM address from rx / conv / tx
- m{0,1,2}_din  in  DATA_W each  write data from each engine
- m{0,1,2}_we, m{0,1,2}_se  in  1 each  write enable and sense enable from each engine
- sram_row, sram_col  out  ADDR_W  muxed address to SRAM
- sram_din  out  DATA_W  muxed write data to SRAM
- sram_we, sram_se  out  1  muxed enables to SRAM
- grant  out  3  one-hot, registered: bit0 rx, bit1 conv, bit2 tx
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job completion
- nobusy  out  3  sticky: the corresponding phase completed via timeout; cleared on accepted start

Behaviour:
- Reset (asynchronous on rstn low): state IDLE; grant, busy, done, nobusy and all *_en = 0; timeout counter = 0.
- FSM states: IDLE, LAUNCH, WAIT_RISE, WAIT_FALL, FINISH. A 2-bit phase register holds RX, CONV or TX.
- IDLE -> LAUNCH on start:
  - phase = RX; bypass latched from cfg_bypass; nobusy cleared.
  - busy = 1 from the next cycle.
- LAUNCH (exactly 1 cycle):
  - Assert the phase's *_en for exactly this cycle.
  - grant is already set to the phase's bit on entry to LAUNCH.
  - Timeout counter = 0. Next state WAIT_RISE.
- WAIT_RISE:
  - Selected busy = 1 -> WAIT_FALL.
  - Otherwise increment the counter. If the counter reaches START_TO: set nobusy[phase] and treat the phase as complete (same as a WAIT_FALL exit).
- WAIT_FALL: stay until the selected busy = 0, then advance the phase:
  - RX -> CONV, or RX -> TX if bypass is latched.
  - CONV -> TX.
  - TX -> FINISH.
  - Any phase other than the last returns to LAUNCH with grant updated in the same edge.
- Phase handover: no dead cycle beyond the one LAUNCH cycle. Phase-to-phase gap = 1 cycle after busy falls.
- FINISH (1 cycle): done = 1, grant = 0, busy = 0 on the following cycle, then IDLE.
- SRAM mux (combinational from the registered grant):
  - sram_* = fields of the granted master.
  - grant = 0 -> sram_we = 0, sram_se = 0, sram_row/col/din = 0.
  - Ungranted masters' we/se have no effect on the SRAM.
- abort in any non-IDLE state:
  - Next cycle: IDLE, grant = 0, busy = 0, no *_en pulse, no done.
  - abort has priority over every other transition.
  - abort in IDLE has no effect.
- start while busy = 1 is ignored. start and abort together in IDLE -> abort wins and the job does not start.
- Busy already high at LAUNCH (stale engine): WAIT_RISE exits next cycle; no special handling.
- Counter width 4 bits, saturating; it is not compared after exit.

Test Plan:
- Full job, bypass = 0:
  - Stimulus: each engine model raises busy 1 cycle after its en and holds it 20 cycles.
  - Required: rx_en, conv_en, tx_en each pulse once, in that order. grant = 001 -> 010 -> 100 -> 000. done pulses once, 1 cycle after tx_busy falls. nobusy = 000.
- Bypass job, cfg_bypass = 1 at start:
  - Required: conv_en never asserts. grant never equals 010. tx_en fires 1 cycle after rx_busy falls.
- Mux isolation, grant = 001:
  - Stimulus: all three masters drive distinct row/col/din and we = 1.
  - Required: sram_* equals master 0 fields exactly.
  - After grant = 0: sram_we = 0, sram_se = 0, sram_row = 0.
- Busy timeout, START_TO = 4:
  - Stimulus: rx engine never raises busy.
  - Required: 4 WAIT_RISE cycles, then conv_en. nobusy = 001 at done. nobusy clears on the next start.
- Abort mid-CONV:
  - Stimulus: abort pulse while conv_busy = 1.
  - Required: next cycle busy = 0, grant = 000. No tx_en and no done. A later start runs a clean full job.
- Reset mid-job:
  - Stimulus: rstn low during WAIT_FALL of TX.
  - Required: all outputs 0 immediately (asynchronously). A start after rstn rises begins at rx_en.
